// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: streams even-aligned instruction pairs from a synchronous
// instruction memory into a small circular buffer and hands one pair per fetch_next to the core.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 9,
  parameter int IW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       im_en,
  output logic [AW-1:0]              im_maddr,
  input  logic [IW-1:0]              im_rdata0,
  input  logic [IW-1:0]              im_rdata1,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  input  logic                       fetch_next,
  output logic                       deq_valid,
  output logic [AW-1:0]              deq_pc,
  output logic [IW-1:0]              deq_ir0,
  output logic [IW-1:0]              deq_ir1,
  output logic                       deq_slot0_invalid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [AW-1:0] fpc;
  logic          inf_v;
  logic [AW-1:0] inf_pc;
  logic          inf_odd;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [AW-1:0] pc_mem  [DEPTH];
  logic [IW-1:0] ir0_mem [DEPTH];
  logic [IW-1:0] ir1_mem [DEPTH];
  logic          odd_mem [DEPTH];

  logic          credit_ok;
  logic          issue;
  logic [AW-1:0] issue_addr;
  logic          wr_en;
  logic          fire;

  // Counting the in-flight read as occupied guarantees its return always finds a free slot.
  assign credit_ok  = ({1'b0, count} + (CW+1)'(inf_v)) < DEPTH_C;
  assign issue      = !rst && (redirect || credit_ok);
  assign issue_addr = redirect ? {redirect_pc[AW-1:1], 1'b0} : fpc;
  assign im_en      = issue;
  assign im_maddr   = rst ? '0 : issue_addr;

  assign wr_en     = inf_v && !redirect;
  assign deq_valid = (count != '0);
  assign fire      = deq_valid && fetch_next;

  assign deq_pc            = pc_mem[rd_ptr];
  assign deq_ir0           = ir0_mem[rd_ptr];
  assign deq_ir1           = ir1_mem[rd_ptr];
  assign deq_slot0_invalid = odd_mem[rd_ptr];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pc_mem[gi]  <= '0;
        ir0_mem[gi] <= '0;
        ir1_mem[gi] <= '0;
        odd_mem[gi] <= 1'b0;
      end else if (wr_en && (wr_ptr == PW'(gi))) begin
        pc_mem[gi]  <= inf_pc;
        ir0_mem[gi] <= im_rdata0;
        ir1_mem[gi] <= im_rdata1;
        odd_mem[gi] <= inf_odd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc     <= '0;
      inf_v   <= 1'b0;
      inf_pc  <= '0;
      inf_odd <= 1'b0;
    end else if (issue) begin
      fpc     <= issue_addr + AW'(2);
      inf_v   <= 1'b1;
      // The tag keeps the unaligned target so the head reports the true branch PC.
      inf_pc  <= redirect ? redirect_pc : issue_addr;
      inf_odd <= redirect & redirect_pc[0];
    end else begin
      inf_v   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (fire)  rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: IM model returns addr*0x11, checks dequeue order,
// back-pressure, redirect flush, address wrap and asynchronous reset.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 9;
  localparam int IW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          im_en;
  logic [AW-1:0] im_maddr;
  logic [IW-1:0] im_rdata0 = '0;
  logic [IW-1:0] im_rdata1 = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          fetch_next = 1'b0;
  logic          deq_valid;
  logic [AW-1:0] deq_pc;
  logic [IW-1:0] deq_ir0;
  logic [IW-1:0] deq_ir1;
  logic          deq_slot0_invalid;
  logic [$clog2(DEPTH):0] count;

  int n_cmp = 0;
  int n_bad = 0;

  inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk               (clk),
    .rst               (rst),
    .im_en             (im_en),
    .im_maddr          (im_maddr),
    .im_rdata0         (im_rdata0),
    .im_rdata1         (im_rdata1),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .fetch_next        (fetch_next),
    .deq_valid         (deq_valid),
    .deq_pc            (deq_pc),
    .deq_ir0           (deq_ir0),
    .deq_ir1           (deq_ir1),
    .deq_slot0_invalid (deq_slot0_invalid),
    .count             (count)
  );

  always #5 clk = ~clk;

  // Synchronous IM: word at address a holds a*0x11.
  always @(posedge clk) begin
    if (im_en) begin
      im_rdata0 <= IW'(im_maddr * 17);
      im_rdata1 <= IW'((im_maddr + 1) * 17);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("  ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Hold reset two cycles; returns at the negedge that starts cycle 0.
  task automatic do_reset(input logic fn);
    tick();
    rst = 1'b1;
    redirect = 1'b0;
    fetch_next = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    fetch_next = fn;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    #1;
    check_val("rst_im_en", im_en, 0);
    check_val("rst_maddr", im_maddr, 0);
    check_val("rst_deq_valid", deq_valid, 0);
    check_val("rst_count", count, 0);
    check_val("rst_deq_pc", deq_pc, 0);
    check_val("rst_slot0", deq_slot0_invalid, 0);

    // Streaming with fetch_next held high
    do_reset(1'b1);
    #1;
    check_val("c0_im_en", im_en, 1);
    check_val("c0_maddr", im_maddr, 0);
    check_val("c0_deq_valid", deq_valid, 0);
    tick(); #1;
    check_val("c1_deq_valid", deq_valid, 0);
    tick(); #1;
    check_val("c2_deq_valid", deq_valid, 1);
    check_val("c2_pc", deq_pc, 0);
    check_val("c2_ir0", deq_ir0, 16'h0000);
    check_val("c2_ir1", deq_ir1, 16'h0011);
    check_val("c2_count", count, 1);
    for (int k = 1; k <= 3; k++) begin
      tick(); #1;
      $display("stream pair %0d", k);
      check_val("stream_pc", deq_pc, 2 * k);
      check_val("stream_ir0", deq_ir0, 2 * k * 17);
      check_val("stream_count", count, 1);
    end

    // Consumer stalled: fill to DEPTH, then drain in order
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) tick();
    #1;
    check_val("full_count", count, 4);
    check_val("full_im_en", im_en, 0);
    check_val("full_fpc", im_maddr, 8);
    fetch_next = 1'b1;
    #1;
    check_val("drain_pc0", deq_pc, 0);
    tick(); #1;
    check_val("drain_pc1", deq_pc, 2);
    check_val("drain_count1", count, 3);
    check_val("resume_im_en", im_en, 1);
    check_val("resume_maddr", im_maddr, 8);
    for (int k = 2; k <= 4; k++) begin
      tick(); #1;
      check_val("drain_pc", deq_pc, 2 * k);
      check_val("drain_valid", deq_valid, 1);
    end

    // Redirect to odd target with 3 queued, an in-flight return and a fire
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) tick();
    #1;
    check_val("pre_redir_count", count, 3);
    redirect = 1'b1;
    redirect_pc = 9'h025;
    fetch_next = 1'b1;
    #1;
    check_val("redir_im_en", im_en, 1);
    check_val("redir_maddr", im_maddr, 9'h024);
    tick();
    redirect = 1'b0;
    fetch_next = 1'b0;
    #1;
    check_val("redir_t1_count", count, 0);
    check_val("redir_t1_valid", deq_valid, 0);
    check_val("redir_t1_maddr", im_maddr, 9'h026);
    tick(); #1;
    check_val("redir_t2_valid", deq_valid, 1);
    check_val("redir_t2_pc", deq_pc, 9'h025);
    check_val("redir_t2_slot0", deq_slot0_invalid, 1);
    check_val("redir_t2_ir0", deq_ir0, 16'h0264);
    check_val("redir_t2_ir1", deq_ir1, 16'h0275);
    check_val("redir_t2_count", count, 1);
    fetch_next = 1'b1;
    tick(); #1;
    check_val("redir_t3_pc", deq_pc, 9'h026);
    check_val("redir_t3_slot0", deq_slot0_invalid, 0);
    check_val("redir_t3_ir0", deq_ir0, 16'h0286);
    check_val("redir_t3_count", count, 1);

    // Fetch address wrap at the top of IM
    tick();
    redirect = 1'b1;
    redirect_pc = 9'h1FE;
    #1;
    check_val("wrap_maddr", im_maddr, 9'h1FE);
    tick();
    redirect = 1'b0;
    #1;
    check_val("wrap_t1_valid", deq_valid, 0);
    check_val("wrap_t1_maddr", im_maddr, 9'h000);
    tick(); #1;
    check_val("wrap_t2_pc", deq_pc, 9'h1FE);
    check_val("wrap_t2_ir0", deq_ir0, 16'h21DE);
    check_val("wrap_t2_ir1", deq_ir1, 16'h21EF);
    check_val("wrap_t2_slot0", deq_slot0_invalid, 0);
    tick(); #1;
    check_val("wrap_t3_pc", deq_pc, 9'h000);
    check_val("wrap_t3_ir0", deq_ir0, 16'h0000);
    check_val("wrap_t3_ir1", deq_ir1, 16'h0011);

    // Asynchronous reset mid-stream with two entries queued
    tick();
    redirect = 1'b1;
    redirect_pc = 9'h040;
    fetch_next = 1'b0;
    tick();
    redirect = 1'b0;
    tick();
    tick(); #1;
    check_val("pre_arst_count", count, 2);
    check_val("pre_arst_pc", deq_pc, 9'h040);
    rst = 1'b1;
    #1;
    check_val("arst_valid", deq_valid, 0);
    check_val("arst_count", count, 0);
    check_val("arst_im_en", im_en, 0);
    check_val("arst_deq_pc", deq_pc, 0);
    tick();
    rst = 1'b0;
    fetch_next = 1'b1;
    #1;
    check_val("restart_im_en", im_en, 1);
    check_val("restart_maddr", im_maddr, 0);
    tick();
    tick(); #1;
    check_val("restart_valid", deq_valid, 1);
    check_val("restart_pc", deq_pc, 0);
    check_val("restart_ir1", deq_ir1, 16'h0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
